// File: rtl/ei_axi4_pkg.sv
// Shared widths, enums and helpers for the ei_axi4_interface passive AXI4 monitor.
package ei_axi4_pkg;

   localparam int ADDR_WIDTH_DEF      = 32;
   localparam int DATA_WIDTH_DEF      = 32;
   localparam int ID_WIDTH_DEF        = 4;
   localparam int MAX_OUTSTANDING_DEF = 8;
   localparam int NUM_CHAN            = 5;
   localparam int NUM_CODES           = 7;

   typedef enum logic [1:0] {
      BURST_FIXED = 2'd0,
      BURST_INCR  = 2'd1,
      BURST_WRAP  = 2'd2
   } burst_e;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'd0,
      RESP_EXOKAY = 2'd1,
      RESP_SLVERR = 2'd2,
      RESP_DECERR = 2'd3
   } resp_e;

   typedef enum logic [3:0] {
      ERR_NONE        = 4'd0,
      ERR_VALID_DROP  = 4'd1,
      ERR_PAYLOAD_CHG = 4'd2,
      ERR_WLAST       = 4'd3,
      ERR_W_NO_AW     = 4'd4,
      ERR_B_NO_AW     = 4'd5,
      ERR_R_NO_AR     = 4'd6,
      ERR_OVERFLOW    = 4'd7
   } err_code_e;

   typedef enum logic [2:0] {
      CHAN_AW = 3'd0,
      CHAN_W  = 3'd1,
      CHAN_B  = 3'd2,
      CHAN_AR = 3'd3,
      CHAN_R  = 3'd4
   } chan_e;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/ei_axi4_chan_checker.sv
// Per-channel VALID/READY stability checker: flags VALID drops and payload changes
// while a transfer is stalled. History is cleared by reset, so the first edge checks nothing.
module ei_axi4_chan_checker
   import ei_axi4_pkg::*;
#(
   parameter int PAYLOAD_W = 1
) (
   input  logic                 aclk,
   input  logic                 aresetn,
   input  logic                 valid,
   input  logic                 ready,
   input  logic [PAYLOAD_W-1:0] payload,
   output logic                 vdrop_err,
   output logic                 stab_err,
   output logic                 hs
);

   logic                 r_stalled;
   logic [PAYLOAD_W-1:0] r_payload;

   assign hs        = valid & ready;
   assign vdrop_err = r_stalled & ~valid;
   assign stab_err  = r_stalled & valid & (payload != r_payload);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_stalled <= 1'b0;
         r_payload <= '0;
      end else begin
         r_stalled <= valid & ~ready;
         r_payload <= payload;
      end
   end

endmodule

// File: rtl/ei_axi4_interface.sv
// Passive AXI4 monitor: outstanding-burst counters and coded protocol-error pulses.
// Define EI_AXI4_BURST_CHECK_EN to compile in the awlen FIFO, W beat counting and codes 3/4.
module ei_axi4_interface
   import ei_axi4_pkg::*;
#(
   parameter int ADDR_WIDTH      = ADDR_WIDTH_DEF,
   parameter int DATA_WIDTH      = DATA_WIDTH_DEF,
   parameter int ID_WIDTH        = ID_WIDTH_DEF,
   parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF
) (
   input  logic                                       aclk,
   input  logic                                       aresetn,
   input  logic                                       awvalid,
   input  logic                                       awready,
   input  logic [ID_WIDTH-1:0]                        awid,
   input  logic [ADDR_WIDTH-1:0]                      awaddr,
   input  logic [7:0]                                 awlen,
   input  logic [2:0]                                 awsize,
   input  logic [1:0]                                 awburst,
   input  logic                                       wvalid,
   input  logic                                       wready,
   input  logic [DATA_WIDTH-1:0]                      wdata,
   input  logic [DATA_WIDTH/8-1:0]                    wstrb,
   input  logic                                       wlast,
   input  logic                                       bvalid,
   input  logic                                       bready,
   input  logic [ID_WIDTH-1:0]                        bid,
   input  logic [1:0]                                 bresp,
   input  logic                                       arvalid,
   input  logic                                       arready,
   input  logic [ID_WIDTH-1:0]                        arid,
   input  logic [ADDR_WIDTH-1:0]                      araddr,
   input  logic [7:0]                                 arlen,
   input  logic [2:0]                                 arsize,
   input  logic [1:0]                                 arburst,
   input  logic                                       rvalid,
   input  logic                                       rready,
   input  logic [ID_WIDTH-1:0]                        rid,
   input  logic [DATA_WIDTH-1:0]                      rdata,
   input  logic [1:0]                                 rresp,
   input  logic                                       rlast,
   output logic                                       err_valid,
   output logic [3:0]                                 err_code,
   output logic [2:0]                                 err_chan,
   output logic [15:0]                                err_count,
   output logic [$clog2(MAX_OUTSTANDING+1)-1:0]       wr_outstanding,
   output logic [$clog2(MAX_OUTSTANDING+1)-1:0]       rd_outstanding
);

   localparam int CW   = $clog2(MAX_OUTSTANDING + 1);
   localparam int AX_W = ID_WIDTH + ADDR_WIDTH + 8 + 3 + 2;
   localparam int W_W  = DATA_WIDTH + DATA_WIDTH / 8 + 1;
   localparam int B_W  = ID_WIDTH + 2;
   localparam int R_W  = ID_WIDTH + DATA_WIDTH + 2 + 1;

   logic [NUM_CHAN-1:0] w_vdrop, w_stab;
   logic                w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
   logic                w_wr_inc, w_wr_dec, w_rd_inc, w_rd_dec;
   logic                w_wlast_err, w_w_no_aw;

   logic [CW-1:0]       r_wr_out, r_rd_out;
   logic                r_err_valid;
   err_code_e           r_err_code;
   chan_e               r_err_chan;
   logic [15:0]         r_err_count;

   ei_axi4_chan_checker #(.PAYLOAD_W(AX_W)) u_aw_chk (
      .aclk(aclk), .aresetn(aresetn), .valid(awvalid), .ready(awready),
      .payload({awid, awaddr, awlen, awsize, awburst}),
      .vdrop_err(w_vdrop[CHAN_AW]), .stab_err(w_stab[CHAN_AW]), .hs(w_aw_hs));

   ei_axi4_chan_checker #(.PAYLOAD_W(W_W)) u_w_chk (
      .aclk(aclk), .aresetn(aresetn), .valid(wvalid), .ready(wready),
      .payload({wdata, wstrb, wlast}),
      .vdrop_err(w_vdrop[CHAN_W]), .stab_err(w_stab[CHAN_W]), .hs(w_w_hs));

   ei_axi4_chan_checker #(.PAYLOAD_W(B_W)) u_b_chk (
      .aclk(aclk), .aresetn(aresetn), .valid(bvalid), .ready(bready),
      .payload({bid, bresp}),
      .vdrop_err(w_vdrop[CHAN_B]), .stab_err(w_stab[CHAN_B]), .hs(w_b_hs));

   ei_axi4_chan_checker #(.PAYLOAD_W(AX_W)) u_ar_chk (
      .aclk(aclk), .aresetn(aresetn), .valid(arvalid), .ready(arready),
      .payload({arid, araddr, arlen, arsize, arburst}),
      .vdrop_err(w_vdrop[CHAN_AR]), .stab_err(w_stab[CHAN_AR]), .hs(w_ar_hs));

   ei_axi4_chan_checker #(.PAYLOAD_W(R_W)) u_r_chk (
      .aclk(aclk), .aresetn(aresetn), .valid(rvalid), .ready(rready),
      .payload({rid, rdata, rresp, rlast}),
      .vdrop_err(w_vdrop[CHAN_R]), .stab_err(w_stab[CHAN_R]), .hs(w_r_hs));

   // A full counter rejects the new burst; an empty one ignores the completion.
   assign w_wr_inc = w_aw_hs && (r_wr_out != CW'(MAX_OUTSTANDING));
   assign w_wr_dec = w_b_hs  && (r_wr_out != '0);
   assign w_rd_inc = w_ar_hs && (r_rd_out != CW'(MAX_OUTSTANDING));
   assign w_rd_dec = w_r_hs  && rlast && (r_rd_out != '0);

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_wr_out <= '0;
         r_rd_out <= '0;
      end else begin
         if (w_wr_inc && !w_wr_dec)      r_wr_out <= r_wr_out + 1'b1;
         else if (w_wr_dec && !w_wr_inc) r_wr_out <= r_wr_out - 1'b1;
         if (w_rd_inc && !w_rd_dec)      r_rd_out <= r_rd_out + 1'b1;
         else if (w_rd_dec && !w_rd_inc) r_rd_out <= r_rd_out - 1'b1;
      end
   end

`ifdef EI_AXI4_BURST_CHECK_EN
   localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

   logic [7:0]    r_len_fifo [MAX_OUTSTANDING];
   logic [PW-1:0] r_rd_ptr, r_wr_ptr;
   logic [CW-1:0] r_fifo_cnt;
   logic [8:0]    r_beat;
   logic [8:0]    w_exp_beats, w_beat_n;
   logic          w_fifo_empty, w_fifo_full, w_final, w_w_ok, w_pop, w_push;

   assign w_fifo_empty = (r_fifo_cnt == '0);
   assign w_fifo_full  = (r_fifo_cnt == CW'(MAX_OUTSTANDING));
   assign w_exp_beats  = {1'b0, r_len_fifo[r_rd_ptr]} + 9'd1;
   assign w_beat_n     = r_beat + 9'd1;
   assign w_final      = (w_beat_n == w_exp_beats);
   assign w_w_ok       = w_w_hs && !w_fifo_empty;
   assign w_pop        = w_w_ok && (wlast || w_final);
   assign w_push       = w_wr_inc && (!w_fifo_full || w_pop);
   assign w_wlast_err  = w_w_ok && (wlast != w_final);
   assign w_w_no_aw    = w_w_hs && w_fifo_empty;

   // NOTE: the length FIFO is reset as well, so a burst cut by reset leaves no stale lengths.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         for (int i = 0; i < MAX_OUTSTANDING; i++) r_len_fifo[i] <= '0;
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
         r_fifo_cnt <= '0;
         r_beat     <= '0;
      end else begin
         if (w_push) begin
            r_len_fifo[r_wr_ptr] <= awlen;
            r_wr_ptr <= (r_wr_ptr == PW'(MAX_OUTSTANDING - 1)) ? '0 : r_wr_ptr + 1'b1;
         end
         if (w_pop)
            r_rd_ptr <= (r_rd_ptr == PW'(MAX_OUTSTANDING - 1)) ? '0 : r_rd_ptr + 1'b1;
         if (w_push && !w_pop)      r_fifo_cnt <= r_fifo_cnt + 1'b1;
         else if (w_pop && !w_push) r_fifo_cnt <= r_fifo_cnt - 1'b1;
         if (w_pop)       r_beat <= '0;
         else if (w_w_ok) r_beat <= w_beat_n;
      end
   end
`else
   logic w_w_hs_unused;
   assign w_w_hs_unused = w_w_hs;
   assign w_wlast_err   = 1'b0;
   assign w_w_no_aw     = 1'b0;
`endif

   logic [NUM_CODES:1][NUM_CHAN-1:0] w_flags;
   logic                             w_sel_valid;
   err_code_e                        w_sel_code;
   chan_e                            w_sel_chan;

   // NOTE: every always_comb output is defaulted first, so no path can infer a latch.
   always_comb begin
      w_flags             = '0;
      w_flags[1]          = w_vdrop;
      w_flags[2]          = w_stab;
      w_flags[3][CHAN_W]  = w_wlast_err;
      w_flags[4][CHAN_W]  = w_w_no_aw;
      w_flags[5][CHAN_B]  = w_b_hs && (r_wr_out == '0);
      w_flags[6][CHAN_R]  = w_r_hs && (r_rd_out == '0);
      w_flags[7][CHAN_AW] = w_aw_hs && (r_wr_out == CW'(MAX_OUTSTANDING));
      w_flags[7][CHAN_AR] = w_ar_hs && (r_rd_out == CW'(MAX_OUTSTANDING));
   end

   // Lowest code wins, then lowest channel.
   always_comb begin
      w_sel_valid = 1'b0;
      w_sel_code  = ERR_NONE;
      w_sel_chan  = CHAN_AW;
      for (int c = 1; c <= NUM_CODES; c++) begin
         for (int ch = 0; ch < NUM_CHAN; ch++) begin
            if (!w_sel_valid && w_flags[c][ch]) begin
               w_sel_valid = 1'b1;
               w_sel_code  = err_code_e'(c[3:0]);
               w_sel_chan  = chan_e'(ch[2:0]);
            end
         end
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_err_valid <= 1'b0;
         r_err_code  <= ERR_NONE;
         r_err_chan  <= CHAN_AW;
         r_err_count <= '0;
      end else begin
         r_err_valid <= w_sel_valid;
         r_err_code  <= w_sel_code;
         r_err_chan  <= w_sel_chan;
         if (w_sel_valid) r_err_count <= sat_inc16(r_err_count);
      end
   end

   assign err_valid      = r_err_valid;
   assign err_code       = r_err_code;
   assign err_chan       = r_err_chan;
   assign err_count      = r_err_count;
   assign wr_outstanding = r_wr_out;
   assign rd_outstanding = r_rd_out;

endmodule

// File: tb/tb_ei_axi4_interface.sv
// Self-checking bench for ei_axi4_interface: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level model (honours EI_AXI4_BURST_CHECK_EN).
module tb_ei_axi4_interface;
   import ei_axi4_pkg::*;

   localparam int MAXO = 8;

   logic        aclk = 1'b0;
   logic        aresetn = 1'b1;
   logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
   logic        arvalid, arready, rvalid, rready, rlast;
   logic [3:0]  awid, bid, arid, rid, wstrb;
   logic [31:0] awaddr, araddr, wdata, rdata;
   logic [7:0]  awlen, arlen;
   logic [2:0]  awsize, arsize;
   logic [1:0]  awburst, arburst, bresp, rresp;
   logic        err_valid;
   logic [3:0]  err_code;
   logic [2:0]  err_chan;
   logic [15:0] err_count;
   logic [3:0]  wr_outstanding, rd_outstanding;

   int n_pass = 0;
   int n_total = 0;

   always #5 aclk = ~aclk;

   ei_axi4_interface #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4), .MAX_OUTSTANDING(MAXO)
   ) dut (
      .aclk(aclk), .aresetn(aresetn),
      .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr),
      .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
      .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
      .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr),
      .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
      .err_valid(err_valid), .err_code(err_code), .err_chan(err_chan),
      .err_count(err_count), .wr_outstanding(wr_outstanding), .rd_outstanding(rd_outstanding)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // ---------------- transaction-level reference model ----------------
   bit          m_valid;
   int          m_code, m_chan, m_cnt, m_wr, m_rd;
   bit          m_stall [5];
   logic [127:0] m_prev [5];
   int          m_q [$];
   int          m_beats;

   always @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         m_valid = 0; m_code = 0; m_chan = 0; m_cnt = 0; m_wr = 0; m_rd = 0;
         m_q.delete(); m_beats = 0;
         for (int ch = 0; ch < 5; ch++) begin m_stall[ch] = 0; m_prev[ch] = '0; end
      end else begin
         bit           v [5];
         bit           r [5];
         logic [127:0] p [5];
         bit           f [8][5];
         int           nw, nr;
         v = '{awvalid, wvalid, bvalid, arvalid, rvalid};
         r = '{awready, wready, bready, arready, rready};
         p = '{128'({awid, awaddr, awlen, awsize, awburst}), 128'({wdata, wstrb, wlast}),
               128'({bid, bresp}), 128'({arid, araddr, arlen, arsize, arburst}),
               128'({rid, rdata, rresp, rlast})};
         for (int c = 0; c < 8; c++) for (int ch = 0; ch < 5; ch++) f[c][ch] = 0;
         for (int ch = 0; ch < 5; ch++) begin
            if (m_stall[ch]) begin
               if (!v[ch]) f[1][ch] = 1;
               else if (p[ch] != m_prev[ch]) f[2][ch] = 1;
            end
            m_stall[ch] = v[ch] && !r[ch];
            m_prev[ch]  = p[ch];
         end
         nw = m_wr; nr = m_rd;
`ifdef EI_AXI4_BURST_CHECK_EN
         if (v[1] && r[1]) begin
            if (m_q.size() == 0) f[4][1] = 1;
            else begin
               m_beats++;
               if (wlast != (m_beats == m_q[0] + 1)) f[3][1] = 1;
               if (wlast || m_beats == m_q[0] + 1) begin
                  void'(m_q.pop_front());
                  m_beats = 0;
               end
            end
         end
`endif
         if (v[0] && r[0]) begin
            if (m_wr == MAXO) f[7][0] = 1;
            else begin
               nw++;
`ifdef EI_AXI4_BURST_CHECK_EN
               if (m_q.size() < MAXO) m_q.push_back(int'(awlen));
`endif
            end
         end
         if (v[2] && r[2]) begin if (m_wr == 0) f[5][2] = 1; else nw--; end
         if (v[3] && r[3]) begin if (m_rd == MAXO) f[7][3] = 1; else nr++; end
         if (v[4] && r[4]) begin if (m_rd == 0) f[6][4] = 1; else if (rlast) nr--; end
         m_wr = nw; m_rd = nr;
         m_valid = 0; m_code = 0; m_chan = 0;
         for (int c = 1; c < 8; c++)
            for (int ch = 0; ch < 5; ch++)
               if (!m_valid && f[c][ch]) begin m_valid = 1; m_code = c; m_chan = ch; end
         if (m_valid && m_cnt < 65535) m_cnt++;
      end
   end

   // Compare every cycle, half a period after the active edge.
   bit cmp_en = 0;
   always @(negedge aclk) begin
      if (cmp_en) begin
         check("err_valid", 32'(err_valid), 32'(m_valid));
         check("err_code", 32'(err_code), 32'(m_code));
         check("err_chan", 32'(err_chan), 32'(m_chan));
         check("err_count", 32'(err_count), 32'(m_cnt));
         check("wr_outstanding", 32'(wr_outstanding), 32'(m_wr));
         check("rd_outstanding", 32'(rd_outstanding), 32'(m_rd));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic cyc();
      @(negedge aclk);
      #1;
   endtask

   task automatic idle();
      awvalid = 0; awready = 0; awid = 0; awaddr = 0; awlen = 0; awsize = 3'd2; awburst = BURST_INCR;
      wvalid = 0; wready = 0; wdata = 0; wstrb = 4'hF; wlast = 0;
      bvalid = 0; bready = 0; bid = 0; bresp = RESP_OKAY;
      arvalid = 0; arready = 0; arid = 0; araddr = 0; arlen = 0; arsize = 3'd2; arburst = BURST_INCR;
      rvalid = 0; rready = 0; rid = 0; rdata = 0; rresp = RESP_OKAY; rlast = 0;
   endtask

   task automatic reset_dut();
      idle();
      aresetn = 0;
      cyc();
      cyc();
      aresetn = 1;
   endtask

   function automatic bit chance(input int n);
      return $urandom_range(0, n - 1) == 0;
   endfunction

   task automatic rand_cycle();
      bit s;
      s = awvalid && !awready;
      awvalid = s ? !chance(20) : chance(3);
      if (!s || chance(16)) begin
         awid = 4'($urandom); awaddr = 32'($urandom_range(0, 3) * 4); awlen = 8'($urandom_range(0, 3));
      end
      awready = chance(2);
      s = wvalid && !wready;
      wvalid = s ? !chance(20) : chance(2);
      if (!s || chance(16)) begin
         wdata = $urandom; wstrb = 4'($urandom); wlast = chance(3);
      end
      wready = chance(2);
      s = bvalid && !bready;
      bvalid = s ? !chance(20) : chance(5);
      if (!s || chance(16)) begin bid = 4'($urandom); bresp = 2'($urandom); end
      bready = chance(2);
      s = arvalid && !arready;
      arvalid = s ? !chance(20) : chance(3);
      if (!s || chance(16)) begin
         arid = 4'($urandom); araddr = 32'($urandom_range(0, 3) * 4); arlen = 8'($urandom_range(0, 3));
      end
      arready = chance(2);
      s = rvalid && !rready;
      rvalid = s ? !chance(20) : chance(3);
      if (!s || chance(16)) begin
         rid = 4'($urandom); rdata = $urandom; rresp = 2'($urandom); rlast = chance(2);
      end
      rready = chance(2);
   endtask

   initial begin
      idle();
      #1 aresetn = 0;
      cyc();
      cmp_en = 1;
      cyc();
      aresetn = 1;
      check("reset wr_outstanding", 32'(wr_outstanding), 32'd0);

      // Clean write: AW len 3, four W beats, one B.
      awvalid = 1; awready = 1; awlen = 8'd3; awaddr = 32'h40;
      cyc();
      check("clean wr_outstanding after AW", 32'(wr_outstanding), 32'd1);
      awvalid = 0; awready = 0;
      for (int i = 0; i < 4; i++) begin
         wvalid = 1; wready = 1; wlast = (i == 3); wdata = 32'(i);
         cyc();
      end
      wvalid = 0; wready = 0; wlast = 0;
      bvalid = 1; bready = 1;
      cyc();
      check("clean wr_outstanding after B", 32'(wr_outstanding), 32'd0);
      check("clean err_count", 32'(err_count), 32'd0);
      bvalid = 0; bready = 0;

      // Payload change while stalled.
      reset_dut();
      awvalid = 1; awready = 0; awaddr = 32'h100;
      cyc();
      cyc();
      awaddr = 32'h104;
      cyc();
      check("stab err_valid", 32'(err_valid), 32'd1);
      check("stab err_code", 32'(err_code), 32'd2);
      check("stab err_chan", 32'(err_chan), 32'd0);
      check("stab err_count", 32'(err_count), 32'd1);

      // ARVALID dropped before ARREADY.
      reset_dut();
      arvalid = 1; arready = 0;
      cyc();
      arvalid = 0;
      cyc();
      check("vdrop err_code", 32'(err_code), 32'd1);
      check("vdrop err_chan", 32'(err_chan), 32'd3);

      // Early WLAST on a two-beat burst.
      reset_dut();
      awvalid = 1; awready = 1; awlen = 8'd1;
      cyc();
      awvalid = 0; awready = 0;
      wvalid = 1; wready = 1; wlast = 1;
      cyc();
`ifdef EI_AXI4_BURST_CHECK_EN
      check("wlast err_code", 32'(err_code), 32'd3);
      check("wlast err_chan", 32'(err_chan), 32'd1);
`else
      check("wlast no error", 32'(err_valid), 32'd0);
`endif
      wvalid = 0; wready = 0; wlast = 0;

      // Nine AR handshakes, no R: ninth overflows.
      reset_dut();
      arvalid = 1; arready = 1;
      repeat (8) cyc();
      check("ovf rd_outstanding 8", 32'(rd_outstanding), 32'd8);
      check("ovf no early error", 32'(err_valid), 32'd0);
      cyc();
      check("ovf err_code", 32'(err_code), 32'd7);
      check("ovf err_chan", 32'(err_chan), 32'd3);
      check("ovf rd_outstanding held", 32'(rd_outstanding), 32'd8);
      arvalid = 0; arready = 0;

      // B with nothing outstanding, then asynchronous reset.
      reset_dut();
      bvalid = 1; bready = 1;
      cyc();
      check("b err_code", 32'(err_code), 32'd5);
      check("b err_chan", 32'(err_chan), 32'd2);
      bvalid = 0; bready = 0;
      aresetn = 0;
      #1;
      check("async reset outputs", {err_valid, err_code, err_chan, err_count, wr_outstanding, rd_outstanding}, 32'd0);
      cyc();
      aresetn = 1;

      // Randomized traffic with occasional mid-burst resets.
      for (int n = 0; n < 4000; n++) begin
         rand_cycle();
         if (chance(400)) begin
            aresetn = 0;
            cyc();
            aresetn = 1;
         end
         cyc();
      end
      idle();
      cyc();
      cmp_en = 0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
